// File: rtl/reg_bank_pkg.sv
// Shared types for the register-bank arbiter: bank opcodes, FSM states and opcode decode.
package reg_bank_pkg;

    localparam int OP_W = 2;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_SET   = 2'b01,
        OP_CLEAR = 2'b10,
        OP_READ  = 2'b11
    } op_e;

    // S_IDLE arbitrate | S_DRIVE strobe the bank | S_ACK sample bank_q and ack
    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_ACK
    } state_e;

    // Unknown opcode bits fall through to READ so a bad client never disturbs the bank.
    function automatic op_e decode_op(input logic [OP_W-1:0] bits);
        case (bits)
            2'b00:   return OP_WRITE;
            2'b01:   return OP_SET;
            2'b10:   return OP_CLEAR;
            default: return OP_READ;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first active request at or above ptr, wrapping to 0.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        int k;
        k     = 0;
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            k = (int'(ptr) + i) % N;
            if (!valid && req[k]) begin
                valid    = 1'b1;
                idx      = IDX_W'(k);
                grant[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Round-robin access controller for one shared set/clear register bank.
// Define REG_BANK_ARBITER_LOCK_EN to add the lock port (winner re-granted while locked).
module reg_bank_arbiter
    import reg_bank_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [OP_W*N_REQ-1:0]  op,
    input  logic [WIDTH*N_REQ-1:0] wdata,
`ifdef REG_BANK_ARBITER_LOCK_EN
    input  logic [N_REQ-1:0]       lock,
`endif
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       ack,
    output logic [WIDTH-1:0]       rdata,
    output logic [WIDTH-1:0]       bank_d,
    output logic                   bank_set,
    output logic                   bank_clr,
    output logic                   bank_en,
    input  logic [WIDTH-1:0]       bank_q
);

    localparam int IDX_W = $clog2(N_REQ);

    state_e           state, state_nxt;
    logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;
    logic [IDX_W-1:0] win_idx, win_idx_nxt;
    logic [N_REQ-1:0] win_oh, win_oh_nxt;
    op_e              win_op, win_op_nxt;
    logic [WIDTH-1:0] win_data, win_data_nxt;
    logic [WIDTH-1:0] rdata_q, rdata_nxt;
    logic [IDX_W-1:0] ptr_after_win;
    logic [N_REQ-1:0] arb_grant;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_valid;
    logic             relock;

    rr_arbiter #(.N(N_REQ)) u_rr_arbiter (
        .req   (req),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

`ifdef REG_BANK_ARBITER_LOCK_EN
    assign relock = lock[win_idx];
`else
    assign relock = 1'b0;
`endif

    assign ptr_after_win = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;

    always_comb begin
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        win_idx_nxt  = win_idx;
        win_oh_nxt   = win_oh;
        win_op_nxt   = win_op;
        win_data_nxt = win_data;
        rdata_nxt    = rdata_q;
        case (state)
            S_IDLE: begin
                if (arb_valid) begin
                    state_nxt    = S_DRIVE;
                    win_idx_nxt  = arb_idx;
                    win_oh_nxt   = arb_grant;
                    win_op_nxt   = decode_op(op[arb_idx*OP_W +: OP_W]);
                    win_data_nxt = wdata[arb_idx*WIDTH +: WIDTH];
                end
            end
            S_DRIVE: state_nxt = S_ACK;
            S_ACK: begin
                rdata_nxt = bank_q;
                if (relock) begin
                    // Locked winner keeps the bank: take its new op, pointer stays put.
                    state_nxt    = S_DRIVE;
                    win_op_nxt   = decode_op(op[win_idx*OP_W +: OP_W]);
                    win_data_nxt = wdata[win_idx*WIDTH +: WIDTH];
                end else begin
                    state_nxt  = S_IDLE;
                    rr_ptr_nxt = ptr_after_win;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            rr_ptr   <= '0;
            win_idx  <= '0;
            win_oh   <= '0;
            win_op   <= OP_READ;
            win_data <= '0;
            rdata_q  <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            win_idx  <= win_idx_nxt;
            win_oh   <= win_oh_nxt;
            win_op   <= win_op_nxt;
            win_data <= win_data_nxt;
            rdata_q  <= rdata_nxt;
        end
    end

    // Enable stays high and bank_d recirculates bank_q, so the bank holds unless written.
    assign bank_en  = 1'b1;
    assign bank_d   = (state == S_DRIVE && win_op == OP_WRITE) ? win_data : bank_q;
    assign bank_set = (state == S_DRIVE) && (win_op == OP_SET);
    assign bank_clr = (state == S_DRIVE) && (win_op == OP_CLEAR);
    assign gnt      = (state != S_IDLE) ? win_oh : '0;
    assign ack      = (state == S_ACK) ? win_oh : '0;
    assign rdata    = (state == S_ACK) ? bank_q : rdata_q;

endmodule
